// File: rtl/cache_pmem_arbiter_if.sv
// rtl/cache_pmem_arbiter_if.sv - I-cache, D-cache and physical-memory bus bundle for the pmem arbiter
interface cache_pmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic              icache_pmem_resp;
  logic [LINE_W-1:0] icache_pmem_rdata;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic              dcache_pmem_resp;
  logic [LINE_W-1:0] dcache_pmem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Arbiter side: takes cache requests and memory completions
  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_pmem_resp, icache_pmem_rdata,
    output dcache_pmem_resp, dcache_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // Environment side: caches and physical memory together
  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_pmem_resp, icache_pmem_rdata,
    input  dcache_pmem_resp, dcache_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - shares one pmem port between I-cache and D-cache; ARB_ROUND_ROBIN_EN selects round-robin ties
module cache_pmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_t state;
  state_t state_next;
  logic   i_pend;
  logic   d_pend;
  logic   grant_d;

  assign i_pend = bus.icache_pmem_read;
  assign d_pend = bus.dcache_pmem_read | bus.dcache_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;

  // Remember who won the last grant so a tie goes to the other requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (i_pend || d_pend)) begin
      last_grant_d <= grant_d;
    end
  end

  assign grant_d = d_pend && (!i_pend || !last_grant_d);
`else
  // D-cache wins every tie: a stalled MEM stage blocks the pipeline first
  assign grant_d = d_pend;
`endif

  // Grant register; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; outputs stay zero unless a grant is held
  always_comb begin
    state_next             = state;
    bus.pmem_read          = 1'b0;
    bus.pmem_write         = 1'b0;
    bus.pmem_address       = '0;
    bus.pmem_wdata         = '0;
    bus.icache_pmem_resp   = 1'b0;
    bus.icache_pmem_rdata  = {LINE_W{1'b0}};
    bus.dcache_pmem_resp   = 1'b0;
    bus.dcache_pmem_rdata  = {LINE_W{1'b0}};

    case (state)
      IDLE: begin
        // A pmem_resp here belongs to nobody and is dropped
        if (i_pend || d_pend) begin
          state_next = grant_d ? SERVE_D : SERVE_I;
        end
      end

      SERVE_I: begin
        bus.pmem_read         = 1'b1;
        bus.pmem_address      = bus.icache_pmem_address & LINE_MASK;
        bus.icache_pmem_rdata = bus.pmem_rdata;
        if (bus.pmem_resp) begin
          bus.icache_pmem_resp = 1'b1;
          state_next           = IDLE;
        end
      end

      SERVE_D: begin
        // Write wins if a buggy requester raises both
        bus.pmem_write        = bus.dcache_pmem_write;
        bus.pmem_read         = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        bus.pmem_address      = bus.dcache_pmem_address & LINE_MASK;
        bus.pmem_wdata        = bus.dcache_pmem_write ? bus.dcache_pmem_wdata : {LINE_W{1'b0}};
        bus.dcache_pmem_rdata = bus.pmem_rdata;
        if (bus.pmem_resp) begin
          bus.dcache_pmem_resp = 1'b1;
          state_next           = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // D-cache must never ask for a read and a write at once
  a_no_d_read_write: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(state == SERVE_D && bus.dcache_pmem_read && bus.dcache_pmem_write)
  );

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb/tb_cache_pmem_arbiter.sv - randomized self-checking bench for cache_pmem_arbiter
module tb_cache_pmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // Reference state: what the caches are asking for and who was served last
  logic         m_ip;
  logic [15:0]  m_ia;
  logic         m_dr;
  logic         m_dw;
  logic [15:0]  m_da;
  logic [127:0] m_dwd;
  bit           m_last_d;

  cache_pmem_arbiter_if bus ();

  cache_pmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arbitration rule: a lone requester wins; ties follow the configured policy
  function automatic bit pick_d(input bit ip, input bit dp);
    if (!ip) return 1'b1;
    if (!dp) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic set_i(input logic [15:0] a);
    m_ip = 1'b1; m_ia = a;
    bus.icache_pmem_read = 1'b1;
    bus.icache_pmem_address = a;
  endtask

  task automatic set_d(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] wd);
    m_dr = rd; m_dw = wr; m_da = a; m_dwd = wd;
    bus.dcache_pmem_read = rd;
    bus.dcache_pmem_write = wr;
    bus.dcache_pmem_address = a;
    bus.dcache_pmem_wdata = wd;
  endtask

  task automatic clear_all();
    m_ip = 1'b0; m_dr = 1'b0; m_dw = 1'b0;
    bus.icache_pmem_read = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read = 1'b0;
    bus.dcache_pmem_write = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata = '0;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  // One granted transaction: lat cycles of service, resp on the last, then the turnaround cycle
  task automatic serve(input bit is_d, input int lat, input string tag);
    logic [127:0] rd;
    logic [127:0] drv;
    logic [15:0]  ea;
    logic         er;
    logic         ew;
    logic [127:0] ewd;
    logic [259:0] got;
    logic [259:0] exp;
    ea  = (is_d ? m_da : m_ia) & 16'hFFF0;
    er  = is_d ? (m_dr & ~m_dw) : 1'b1;
    ew  = is_d ? m_dw : 1'b0;
    ewd = (is_d && m_dw) ? m_dwd : 128'd0;
    rd  = rand128();
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      drv = (c == lat - 1) ? rd : 128'd0;
      bus.pmem_resp  = (c == lat - 1);
      bus.pmem_rdata = drv;
      #1;
      n_cmp++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {er, ew, ea}) begin
        n_err++;
        $display("FAIL %s req c%0d: got rd=%b wr=%b addr=%h need rd=%b wr=%b addr=%h", tag, c,
                 bus.pmem_read, bus.pmem_write, bus.pmem_address, er, ew, ea);
      end
      n_cmp++;
      if (bus.pmem_wdata !== ewd) begin
        n_err++;
        $display("FAIL %s wdata c%0d: got %h need %h", tag, c, bus.pmem_wdata, ewd);
      end
      got = {bus.icache_pmem_resp, bus.dcache_pmem_resp, bus.icache_pmem_rdata, bus.dcache_pmem_rdata, 2'b00};
      exp = {(c == lat - 1) && !is_d, (c == lat - 1) && is_d,
             is_d ? 128'd0 : drv, is_d ? drv : 128'd0, 2'b00};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s resp c%0d: got iresp=%b dresp=%b irdata=%h drdata=%h need iresp=%b dresp=%b",
                 tag, c, bus.icache_pmem_resp, bus.dcache_pmem_resp, bus.icache_pmem_rdata,
                 bus.dcache_pmem_rdata, exp[259], exp[258]);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    if (is_d) begin
      m_dr = 1'b0; m_dw = 1'b0;
      bus.dcache_pmem_read = 1'b0;
      bus.dcache_pmem_write = 1'b0;
    end else begin
      m_ip = 1'b0;
      bus.icache_pmem_read = 1'b0;
    end
    #1;
    n_cmp++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
         bus.icache_pmem_resp, bus.dcache_pmem_resp} !== '0) begin
      n_err++;
      $display("FAIL %s turnaround: got rd=%b wr=%b addr=%h iresp=%b dresp=%b need all 0", tag,
               bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
  endtask

  // Serve whatever the model says is pending until nothing is left
  task automatic drain(input string tag);
    bit w;
    while (m_ip || m_dr || m_dw) begin
      w = pick_d(m_ip, m_dr || m_dw);
      m_last_d = w;
      serve(w, $urandom_range(1, 5), tag);
    end
  endtask

  task automatic check_idle_now(input string tag);
    #1;
    n_cmp++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata, bus.icache_pmem_resp,
         bus.dcache_pmem_resp, bus.icache_pmem_rdata, bus.dcache_pmem_rdata} !== '0) begin
      n_err++;
      $display("FAIL %s: got rd=%b wr=%b addr=%h iresp=%b dresp=%b need all outputs 0", tag,
               bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.icache_pmem_resp, bus.dcache_pmem_resp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    m_last_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    m_last_d = 1'b0;
    @(negedge clk);
    check_idle_now("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    set_d(1'b0, 1'b1, 16'h444B, rand128());
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.pmem_write !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_serve_d: got pmem_write=%b need 1", bus.pmem_write);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = rand128();
    check_idle_now("reset_mid_serve_d");
    clear_all();
    m_last_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_now("reset_released_idle");
  endtask

  task automatic test_i_read();
    @(negedge clk);
    set_i(16'h1236);
    check_idle_now("i_read_before_grant");
    m_last_d = 1'b0;
    serve(1'b0, 5, "i_read");
  endtask

  task automatic test_d_write();
    @(negedge clk);
    set_d(1'b0, 1'b1, 16'h8000, {16{8'hA5}});
    check_idle_now("d_write_before_grant");
    m_last_d = 1'b1;
    serve(1'b1, 4, "d_write");
  endtask

  task automatic test_both_same_cycle();
    do_reset();
    @(negedge clk);
    set_i(16'($urandom));
    set_d(1'b1, 1'b0, 16'($urandom), 128'd0);
    check_idle_now("both_before_grant");
    drain("both_same_cycle");
  endtask

  task automatic test_spurious_resp();
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = rand128();
    check_idle_now("spurious_resp");
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    check_idle_now("spurious_after");
    set_i(16'($urandom));
    m_last_d = 1'b0;
    serve(1'b0, 2, "spurious_then_i");
  endtask

  task automatic test_round_robin();
`ifdef ARB_ROUND_ROBIN_EN
    bit w;
    do_reset();
    @(negedge clk);
    set_i(16'($urandom));
    set_d(1'b1, 1'b0, 16'($urandom), 128'd0);
    for (int k = 0; k < 4; k++) begin
      w = pick_d(1'b1, 1'b1);
      m_last_d = w;
      serve(w, $urandom_range(1, 4), "round_robin");
      if (w) set_d(1'b1, 1'b0, 16'($urandom), 128'd0);
      else   set_i(16'($urandom));
    end
    drain("round_robin_tail");
`endif
  endtask

  task automatic test_random();
    logic wr;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      case ($urandom_range(0, 2))
        0: set_i(16'($urandom));
        1: begin
          wr = 1'($urandom);
          set_d(~wr, wr, 16'($urandom), rand128());
        end
        default: begin
          wr = 1'($urandom);
          set_i(16'($urandom));
          set_d(~wr, wr, 16'($urandom), rand128());
        end
      endcase
      check_idle_now("random_before_grant");
      drain("random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_i_read();
    test_d_write();
    test_both_same_cycle();
    test_spurious_resp();
    test_round_robin();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
